dual_issue_scheduler: RTL and testbench
=======================================

// Module: dual_issue_scheduler
// PURPOSE
//  Consumes the instruction pair from the fetch buffer (instruction0 = oldest, instruction1 = next).
//  Decides each cycle whether to issue two, one, or zero instructions and returns freeze1/freeze2/dependency_on_ins2 to the buffer.
//  Tracks in-flight register writes in a per-register countdown scoreboard.
//  Drives registered issue slots into the execute stage.
// PARAMETERS
//  ALU_LAT   1  cycles until a non-load result is forwardable
//  LOAD_LAT  3  cycles until a load result is forwardable
//  CNT_W     3  scoreboard counter width; ALU_LAT, LOAD_LAT <= 2**CNT_W-1
// PORTS
//  clk                input   1   clock
//  n_rst              input   1   reset, asynchronous, active-high
//  en                 input   1   global enable; state holds when low
//  stall_in           input   1   execute/memory back-pressure
//  flush              input   1   redirect; kills next issue
//  nothing_filled     input   1   fetch buffer empty
//  instruction0       input   32  oldest buffered instruction (RV32I)
//  instruction1       input   32  next buffered instruction
//  freeze1            output  1   buffer must not slide; nothing issues
//  freeze2            output  1   back-pressure freeze; also holds fetch PC
//  dependency_on_ins2 output  1   only instruction0 issues; buffer slides by 1
//  issue0_valid       output  1   slot 0 valid (registered)
//  issue0_instr       output  32  slot 0 instruction
//  issue1_valid       output  1   slot 1 valid (registered)
//  issue1_instr       output  32  slot 1 instruction
// BEHAVIOUR
//  - Decode. rs1+rs2 read by OP, BRANCH, STORE. rs1 only read by OP-IMM, LOAD, JALR.
//    rd written by OP, OP-IMM, LOAD, LUI, AUIPC, JAL, JALR. x0 is never a source or destination hazard.
//  - Scoreboard: 32 counters sb[r] of CNT_W bits. A source is ready iff sb[rs]==0.
//  - Combinational stall outputs. When nothing_filled=1 or instruction0==0, all three are 0.
//    freeze2 = stall_in.
//    freeze1 = stall_in | instruction0 source not ready.
//    dependency_on_ins2 = !freeze1 & (any of the following):
//      instruction1==0
//      instruction1 reads instruction0's rd (rd!=0)
//      instruction1 source not ready
//      both instructions are LOAD/STORE (single memory port)
//      either instruction is BRANCH/JAL/JALR
//    freeze1 and dependency_on_ins2 are never high together.
//  - Issue count: n = 0 if freeze1 or the buffer is empty; 1 if dependency_on_ins2; else 2.
//  - Issue registers, updated on clk when en=1:
//    issue0_valid <= (n>=1) & !flush;  issue1_valid <= (n==2) & !flush.
//    issueX_instr <= the corresponding instruction when its slot is issued; otherwise it holds.
//    Result is visible 1 cycle after the decision.
//  - Scoreboard update when en=1:
//    every nonzero sb[r] decrements by 1;
//    each issued writer with rd!=0 loads sb[rd] <= LOAD_LAT for a load, ALU_LAT otherwise;
//    a load of sb[rd] takes priority over the decrement for that entry;
//    on a dual-issue WAW (same rd), instruction1's latency wins.
//  - flush suppresses issue valids only; scoreboard entries of already-issued instructions keep counting.
//  - en=0: scoreboard and issue registers hold. Stall outputs are still evaluated from current state.
//  - Reset, asynchronous: all sb[r]=0, issue valids=0, issue instrs=0. Stall outputs are then 0 or combinational.
//    Reset mid-operation discards all pending hazards.
// TESTING
//  1. ins0=addi x1,x0,5; ins1=addi x2,x0,7; sb clear
//     -> freeze1=0, dep=0; next cycle both valids=1; sb[1]=sb[2]=ALU_LAT.
//  2. ins0=addi x1,x0,1; ins1=add x3,x1,x1
//     -> dep=1; only issue0_valid=1 next cycle; sb[1]=1.
//  3. Issue lw x5,0(x2); next pair ins0=add x6,x5,x0
//     -> freeze1=1 for LOAD_LAT=3 cycles (sb 3,2,1), then issues when sb[5]=0.
//  4. ins0=lw x7,0(x1); ins1=sw x8,4(x1)
//     -> dep=1 (memory port); ins0=beq x1,x2,8 with any ins1 -> dep=1.
//  5. stall_in=1 with a ready pair
//     -> freeze1=freeze2=1, dep=0, valids 0, sb keeps decrementing.
//     flush=1 with a ready pair -> valids 0 and sb[rd] still loaded.
//  6. Assert n_rst while sb[5]=2 and issue0_valid=1
//     -> immediately sb all 0 and valids 0; the following add x6,x5,x0 issues with no freeze.

Source files
------------

// File: rtl/dual_issue_scheduler.sv
// Dual-issue scheduler: decides per cycle whether the oldest one or two
// buffered RV32I instructions can issue, tracks in-flight register writes
// with a per-register countdown scoreboard, and registers the issue slots.
module dual_issue_scheduler #(
    parameter int ALU_LAT  = 1,
    parameter int LOAD_LAT = 3,
    parameter int CNT_W    = 3
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        en,
    input  logic        stall_in,
    input  logic        flush,
    input  logic        nothing_filled,
    input  logic [31:0] instruction0,
    input  logic [31:0] instruction1,
    output logic        freeze1,
    output logic        freeze2,
    output logic        dependency_on_ins2,
    output logic        issue0_valid,
    output logic [31:0] issue0_instr,
    output logic        issue1_valid,
    output logic [31:0] issue1_instr
);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam logic [CNT_W-1:0] ALU_CNT  = CNT_W'(ALU_LAT);
    localparam logic [CNT_W-1:0] LOAD_CNT = CNT_W'(LOAD_LAT);

    function automatic logic uses_rs1(input logic [6:0] op);
        return (op == OPC_OP) || (op == OPC_BRANCH) || (op == OPC_STORE) ||
               (op == OPC_OPIMM) || (op == OPC_LOAD) || (op == OPC_JALR);
    endfunction

    function automatic logic uses_rs2(input logic [6:0] op);
        return (op == OPC_OP) || (op == OPC_BRANCH) || (op == OPC_STORE);
    endfunction

    function automatic logic writes_rd(input logic [6:0] op);
        return (op == OPC_OP) || (op == OPC_OPIMM) || (op == OPC_LOAD) ||
               (op == OPC_LUI) || (op == OPC_AUIPC) || (op == OPC_JAL) ||
               (op == OPC_JALR);
    endfunction

    function automatic logic is_mem(input logic [6:0] op);
        return (op == OPC_LOAD) || (op == OPC_STORE);
    endfunction

    function automatic logic is_ctrl(input logic [6:0] op);
        return (op == OPC_BRANCH) || (op == OPC_JAL) || (op == OPC_JALR);
    endfunction

    logic [CNT_W-1:0] sb_q [32];
    logic [CNT_W-1:0] sb_d [32];

    logic        issue0_valid_q, issue1_valid_q;
    logic [31:0] issue0_instr_q, issue1_instr_q;

    logic [6:0] op0, op1;
    logic [4:0] rd0, rs1_0, rs2_0, rd1, rs1_1, rs2_1;
    logic       wr0, wr1;
    logic       ready0, ready1;
    logic       active, raw, pair_block;
    logic       issue_one, issue_two;

    assign op0   = instruction0[6:0];
    assign rd0   = instruction0[11:7];
    assign rs1_0 = instruction0[19:15];
    assign rs2_0 = instruction0[24:20];
    assign op1   = instruction1[6:0];
    assign rd1   = instruction1[11:7];
    assign rs1_1 = instruction1[19:15];
    assign rs2_1 = instruction1[24:20];

    // x0 never creates a hazard, so destination x0 is treated as "no write".
    assign wr0 = writes_rd(op0) && (rd0 != 5'd0);
    assign wr1 = writes_rd(op1) && (rd1 != 5'd0);

    assign ready0 = (!uses_rs1(op0) || rs1_0 == 5'd0 || sb_q[rs1_0] == '0) &&
                    (!uses_rs2(op0) || rs2_0 == 5'd0 || sb_q[rs2_0] == '0);
    assign ready1 = (!uses_rs1(op1) || rs1_1 == 5'd0 || sb_q[rs1_1] == '0) &&
                    (!uses_rs2(op1) || rs2_1 == 5'd0 || sb_q[rs2_1] == '0);

    // Hazard evaluation and the freeze/slide handshake back to the fetch buffer.
    always_comb begin
        active = !nothing_filled && (instruction0 != 32'd0);
        raw    = wr0 && ((uses_rs1(op1) && rs1_1 == rd0) ||
                         (uses_rs2(op1) && rs2_1 == rd0));
        // Conditions that restrict this cycle to issuing instruction0 alone.
        pair_block = (instruction1 == 32'd0) || raw || !ready1 ||
                     (is_mem(op0) && is_mem(op1)) ||
                     is_ctrl(op0) || is_ctrl(op1);
        freeze2            = active && stall_in;
        freeze1            = active && (stall_in || !ready0);
        dependency_on_ins2 = active && !freeze1 && pair_block;
        issue_one          = active && !freeze1;
        issue_two          = issue_one && !pair_block;
    end

    // Scoreboard next state: decrement, then newly issued writers reload;
    // instruction1 is applied last so it wins a same-rd dual issue.
    always_comb begin
        for (int r = 0; r < 32; r++) begin
            sb_d[r] = sb_q[r];
            if (sb_q[r] != '0) begin
                sb_d[r] = sb_q[r] - CNT_W'(1);
            end
            if (issue_one && wr0 && rd0 == 5'(r)) begin
                sb_d[r] = (op0 == OPC_LOAD) ? LOAD_CNT : ALU_CNT;
            end
            if (issue_two && wr1 && rd1 == 5'(r)) begin
                sb_d[r] = (op1 == OPC_LOAD) ? LOAD_CNT : ALU_CNT;
            end
        end
    end

    // Scoreboard state; flush does not touch it since issued work keeps flowing.
    always_ff @(posedge clk or posedge n_rst) begin
        if (n_rst) begin
            sb_q <= '{default: '0};
        end else if (en) begin
            sb_q <= sb_d;
        end
    end

    // Registered issue slots into execute; instructions hold when not issued.
    always_ff @(posedge clk or posedge n_rst) begin
        if (n_rst) begin
            issue0_valid_q <= 1'b0;
            issue1_valid_q <= 1'b0;
            issue0_instr_q <= 32'd0;
            issue1_instr_q <= 32'd0;
        end else if (en) begin
            issue0_valid_q <= issue_one && !flush;
            issue1_valid_q <= issue_two && !flush;
            if (issue_one && !flush) begin
                issue0_instr_q <= instruction0;
            end
            if (issue_two && !flush) begin
                issue1_instr_q <= instruction1;
            end
        end
    end

    assign issue0_valid = issue0_valid_q;
    assign issue1_valid = issue1_valid_q;
    assign issue0_instr = issue0_instr_q;
    assign issue1_instr = issue1_instr_q;

endmodule

// File: tb/tb_dual_issue_scheduler.sv
// Self-checking bench for dual_issue_scheduler (ALU_LAT=1, LOAD_LAT=3).
module tb_dual_issue_scheduler;

    logic        clk = 1'b0;
    logic        n_rst;
    logic        en;
    logic        stall_in;
    logic        flush;
    logic        nothing_filled;
    logic [31:0] instruction0;
    logic [31:0] instruction1;
    logic        freeze1, freeze2, dependency_on_ins2;
    logic        issue0_valid, issue1_valid;
    logic [31:0] issue0_instr, issue1_instr;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic        v0;
        logic [31:0] i0;
        logic        v1;
        logic [31:0] i1;
        string       name;
    } exp_t;

    exp_t exp_q[$];

    // Bench-side view of what the issue registers should hold.
    logic        ev0 = 1'b0, ev1 = 1'b0;
    logic [31:0] ei0 = 32'd0, ei1 = 32'd0;

    dual_issue_scheduler #(.ALU_LAT(1), .LOAD_LAT(3), .CNT_W(3)) dut (
        .clk               (clk),
        .n_rst             (n_rst),
        .en                (en),
        .stall_in          (stall_in),
        .flush             (flush),
        .nothing_filled    (nothing_filled),
        .instruction0      (instruction0),
        .instruction1      (instruction1),
        .freeze1           (freeze1),
        .freeze2           (freeze2),
        .dependency_on_ins2(dependency_on_ins2),
        .issue0_valid      (issue0_valid),
        .issue0_instr      (issue0_instr),
        .issue1_valid      (issue1_valid),
        .issue1_instr      (issue1_instr)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // RV32I encoders
    function automatic logic [31:0] enc_addi(input int rd, input int rs1, input int imm);
        return {12'(imm), 5'(rs1), 3'b000, 5'(rd), 7'b0010011};
    endfunction
    function automatic logic [31:0] enc_add(input int rd, input int rs1, input int rs2);
        return {7'd0, 5'(rs2), 5'(rs1), 3'b000, 5'(rd), 7'b0110011};
    endfunction
    function automatic logic [31:0] enc_lw(input int rd, input int rs1, input int imm);
        return {12'(imm), 5'(rs1), 3'b010, 5'(rd), 7'b0000011};
    endfunction
    function automatic logic [31:0] enc_sw(input int rs2, input int rs1, input int imm);
        logic [11:0] im;
        im = 12'(imm);
        return {im[11:5], 5'(rs2), 5'(rs1), 3'b010, im[4:0], 7'b0100011};
    endfunction
    function automatic logic [31:0] enc_beq8(input int rs1, input int rs2);
        return {7'd0, 5'(rs2), 5'(rs1), 3'b000, 5'b01000, 7'b1100011};
    endfunction
    function automatic logic [31:0] enc_jal(input int rd);
        return {20'd0, 5'(rd), 7'b1101111};
    endfunction

    // One decision cycle: drive, check combinational outputs mid-cycle,
    // push the expected issue result, then pop and compare after the edge.
    task automatic step(input string nm, input logic [31:0] a, input logic [31:0] b,
                        input logic st, input logic fl, input logic nf, input logic e,
                        input logic ef1, input logic ef2, input logic edep,
                        input logic xv0, input logic xv1);
        exp_t ex;
        exp_t got;
        instruction0   = a;
        instruction1   = b;
        stall_in       = st;
        flush          = fl;
        nothing_filled = nf;
        en             = e;
        #3;
        n_tests++;
        if (freeze1 !== ef1) begin
            n_fail++;
            $display("FAIL %s.freeze1 got=%b exp=%b", nm, freeze1, ef1);
        end
        n_tests++;
        if (freeze2 !== ef2) begin
            n_fail++;
            $display("FAIL %s.freeze2 got=%b exp=%b", nm, freeze2, ef2);
        end
        n_tests++;
        if (dependency_on_ins2 !== edep) begin
            n_fail++;
            $display("FAIL %s.dep got=%b exp=%b", nm, dependency_on_ins2, edep);
        end
        if (e) begin
            ev0 = xv0;
            ev1 = xv1;
            if (xv0) ei0 = a;
            if (xv1) ei1 = b;
        end
        ex.v0 = ev0; ex.i0 = ei0; ex.v1 = ev1; ex.i1 = ei1; ex.name = nm;
        exp_q.push_back(ex);
        @(posedge clk);
        #1;
        got = exp_q.pop_front();
        n_tests++;
        if (issue0_valid !== got.v0 || issue1_valid !== got.v1) begin
            n_fail++;
            $display("FAIL %s.valids got=%b%b exp=%b%b", got.name,
                     issue0_valid, issue1_valid, got.v0, got.v1);
        end
        n_tests++;
        if (issue0_instr !== got.i0 || issue1_instr !== got.i1) begin
            n_fail++;
            $display("FAIL %s.instrs got=%h/%h exp=%h/%h", got.name,
                     issue0_instr, issue1_instr, got.i0, got.i1);
        end
    endtask

    task automatic check_regs_clear(input string nm);
        n_tests++;
        if (issue0_valid !== 1'b0 || issue1_valid !== 1'b0 ||
            issue0_instr !== 32'd0 || issue1_instr !== 32'd0) begin
            n_fail++;
            $display("FAIL %s got=%b%b %h/%h exp=00 0/0", nm,
                     issue0_valid, issue1_valid, issue0_instr, issue1_instr);
        end
        ev0 = 1'b0; ev1 = 1'b0; ei0 = 32'd0; ei1 = 32'd0;
    endtask

    task automatic test_reset();
        n_rst = 1'b1; en = 1'b1; stall_in = 1'b0; flush = 1'b0;
        nothing_filled = 1'b1; instruction0 = 32'd0; instruction1 = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        check_regs_clear("reset_regs");
        n_rst = 1'b0;
        step("empty_buf", enc_addi(1, 0, 5), enc_addi(2, 0, 7), 1'b1, 1'b0, 1'b1, 1'b1,
             0, 0, 0, 0, 0);
        step("ins0_zero", 32'd0, enc_addi(2, 0, 7), 1'b1, 1'b0, 1'b0, 1'b1,
             0, 0, 0, 0, 0);
    endtask

    task automatic test_dual_issue();
        step("dual", enc_addi(1, 0, 5), enc_addi(2, 0, 7), 0, 0, 0, 1, 0, 0, 0, 1, 1);
        // sb[1]=1 after the dual issue: dependent ins0 waits exactly ALU_LAT
        step("alu_wait", enc_add(3, 1, 0), enc_addi(4, 2, 0), 0, 0, 0, 1, 1, 0, 0, 0, 0);
        step("alu_ready", enc_add(3, 1, 0), enc_addi(4, 2, 0), 0, 0, 0, 1, 0, 0, 0, 1, 1);
    endtask

    task automatic test_raw_pair();
        step("raw_pair", enc_addi(1, 0, 1), enc_add(3, 1, 1), 0, 0, 0, 1, 0, 0, 1, 1, 0);
        step("idle", enc_addi(9, 0, 1), enc_addi(9, 0, 1), 0, 0, 1, 1, 0, 0, 0, 0, 0);
    endtask

    task automatic test_load_latency();
        step("lw_issue", enc_lw(5, 2, 0), 32'd0, 0, 0, 0, 1, 0, 0, 1, 1, 0);
        for (int k = 0; k < 3; k++) begin
            step($sformatf("lw_wait%0d", k), enc_add(6, 5, 0), 32'd0, 0, 0, 0, 1,
                 1, 0, 0, 0, 0);
        end
        step("lw_use", enc_add(6, 5, 0), 32'd0, 0, 0, 0, 1, 0, 0, 1, 1, 0);
    endtask

    task automatic test_structural();
        step("mem_port", enc_lw(7, 1, 0), enc_sw(8, 1, 4), 0, 0, 0, 1, 0, 0, 1, 1, 0);
        step("branch0", enc_beq8(1, 2), enc_addi(10, 0, 1), 0, 0, 0, 1, 0, 0, 1, 1, 0);
        step("jal1", enc_addi(11, 0, 1), enc_jal(1), 0, 0, 0, 1, 0, 0, 1, 1, 0);
        // sb[7] still 1 from the load: instruction1 source not ready
        step("ins1_notready", enc_addi(12, 0, 1), enc_add(13, 7, 0), 0, 0, 0, 1,
             0, 0, 1, 1, 0);
        step("x0_no_hazard", enc_addi(0, 0, 1), enc_add(14, 0, 0), 0, 0, 0, 1,
             0, 0, 0, 1, 1);
    endtask

    task automatic test_stall_flush();
        step("pre_stall", enc_addi(17, 0, 1), 32'd0, 0, 0, 0, 1, 0, 0, 1, 1, 0);
        step("stall", enc_addi(15, 0, 1), enc_addi(16, 0, 1), 1, 0, 0, 1, 1, 1, 0, 0, 0);
        // sb[17] kept counting during the stall
        step("post_stall", enc_add(18, 17, 0), enc_addi(16, 0, 1), 0, 0, 0, 1,
             0, 0, 0, 1, 1);
        step("flush", enc_addi(19, 0, 1), enc_addi(20, 0, 1), 0, 1, 0, 1, 0, 0, 0, 0, 0);
        step("flush_sb", enc_add(21, 19, 20), 32'd0, 0, 0, 0, 1, 1, 0, 0, 0, 0);
        step("flush_sb_clr", enc_add(21, 19, 20), 32'd0, 0, 0, 0, 1, 0, 0, 1, 1, 0);
    endtask

    task automatic test_enable();
        step("en_pre", enc_addi(22, 0, 1), 32'd0, 0, 0, 0, 1, 0, 0, 1, 1, 0);
        step("en_off0", enc_add(23, 22, 0), 32'd0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        step("en_off1", enc_add(23, 22, 0), 32'd0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        step("en_on", enc_add(23, 22, 0), 32'd0, 0, 0, 0, 1, 1, 0, 0, 0, 0);
        step("en_issue", enc_add(23, 22, 0), 32'd0, 0, 0, 0, 1, 0, 0, 1, 1, 0);
    endtask

    task automatic test_midreset();
        step("mr_lw", enc_lw(5, 0, 0), 32'd0, 0, 0, 0, 1, 0, 0, 1, 1, 0);
        step("mr_alu", enc_addi(24, 0, 1), 32'd0, 0, 0, 0, 1, 0, 0, 1, 1, 0);
        // sb[5]=2, issue0_valid=1: reset between edges must clear at once
        instruction0 = enc_add(6, 5, 0);
        instruction1 = 32'd0;
        n_rst = 1'b1;
        #2;
        check_regs_clear("midreset_regs");
        n_tests++;
        if (freeze1 !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_freeze1 got=%b exp=0", freeze1);
        end
        n_rst = 1'b0;
        @(posedge clk);
        #1;
        step("after_reset", enc_add(6, 5, 0), 32'd0, 0, 0, 0, 1, 0, 0, 1, 1, 0);
    endtask

    initial begin
        test_reset();
        test_dual_issue();
        test_raw_pair();
        test_load_latency();
        test_structural();
        test_stall_flush();
        test_enable();
        test_midreset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
